// File: rtl/axi4lite_apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge: one transfer in flight, per-channel holding registers,
// fair read/write arbitration and an optional APB wait-state timeout that forces SLVERR.
module axi4lite_apb_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RVALID,
   input  logic                    RREADY,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic                    PREADY,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PSLVERR
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t              state_q, state_d;
   logic                aw_full_q, aw_full_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic                w_full_q, w_full_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [STRB_W-1:0]   w_strb_q, w_strb_d;
   logic                ar_full_q, ar_full_d;
   logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
   logic                last_rd_q, last_rd_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [STRB_W-1:0]   pstrb_q, pstrb_d;
   logic                err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]    tcnt_q, tcnt_d;

   logic wr_pend, rd_pend, grant_rd, resp_done;

   // Ready is a pure function of the holding flag, gated off while reset is held.
   assign AWREADY = ARESETn && !aw_full_q;
   assign WREADY  = ARESETn && !w_full_q;
   assign ARREADY = ARESETn && !ar_full_q;

   assign PSEL    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign PENABLE = (state_q == ST_ACCESS);
   assign PADDR   = paddr_q;
   assign PWRITE  = pwrite_q;
   assign PWDATA  = pwdata_q;
   assign PSTRB   = pstrb_q;

   assign BVALID  = (state_q == ST_RESP) && pwrite_q;
   assign RVALID  = (state_q == ST_RESP) && !pwrite_q;
   assign BRESP   = {BVALID && err_q, 1'b0};
   assign RRESP   = {RVALID && err_q, 1'b0};
   assign RDATA   = rdata_q;

   assign wr_pend   = aw_full_q && w_full_q;
   assign rd_pend   = ar_full_q;
   assign grant_rd  = rd_pend && (!wr_pend || !last_rd_q);
   assign resp_done = (BVALID && BREADY) || (RVALID && RREADY);

   always_comb begin
      state_d   = state_q;
      aw_full_d = aw_full_q;
      aw_addr_d = aw_addr_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      ar_full_d = ar_full_q;
      ar_addr_d = ar_addr_q;
      last_rd_d = last_rd_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      tcnt_d    = tcnt_q;

      if (AWVALID && AWREADY) begin
         aw_full_d = 1'b1;
         aw_addr_d = AWADDR;
      end
      if (WVALID && WREADY) begin
         w_full_d = 1'b1;
         w_data_d = WDATA;
         w_strb_d = WSTRB;
      end
      if (ARVALID && ARREADY) begin
         ar_full_d = 1'b1;
         ar_addr_d = ARADDR;
      end

      case (state_q)
         ST_IDLE: begin
            if (wr_pend || rd_pend) begin
               state_d  = ST_SETUP;
               paddr_d  = grant_rd ? ar_addr_q : aw_addr_q;
               pwrite_d = !grant_rd;
               pwdata_d = grant_rd ? pwdata_q : w_data_q;
               pstrb_d  = grant_rd ? '0 : w_strb_q;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
            tcnt_d  = '0;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               state_d = ST_RESP;
               err_d   = PSLVERR;
               if (!pwrite_q) rdata_d = PRDATA;
            end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TMO_LAST)) begin
               state_d = ST_RESP;
               err_d   = 1'b1;
               if (!pwrite_q) rdata_d = '0;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            // Flags free up only here, so each channel stays blocked until its response retires.
            if (resp_done) begin
               state_d   = ST_IDLE;
               err_d     = 1'b0;
               last_rd_d = !pwrite_q;
               if (pwrite_q) begin
                  aw_full_d = 1'b0;
                  w_full_d  = 1'b0;
               end else begin
                  ar_full_d = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q   <= ST_IDLE;
         aw_full_q <= 1'b0;
         aw_addr_q <= '0;
         w_full_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         ar_full_q <= 1'b0;
         ar_addr_q <= '0;
         last_rd_q <= 1'b1;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         aw_full_q <= aw_full_d;
         aw_addr_q <= aw_addr_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         ar_full_q <= ar_full_d;
         ar_addr_q <= ar_addr_d;
         last_rd_q <= last_rd_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         tcnt_q    <= tcnt_d;
      end
   end

endmodule

// File: tb/tb_axi4lite_apb_bridge.sv
// Directed bench: a transaction-level model (expected APB transfer queue plus response rule)
// is checked every cycle by one compare process that also plays the APB slave.
module tb_axi4lite_apb_bridge;

   localparam int TMO = 16;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic [31:0] AWADDR = '0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [31:0] ARADDR = '0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY = 1'b0;
   logic [31:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic        PREADY = 1'b0;
   logic [31:0] PRDATA = '0;
   logic        PSLVERR = 1'b0;

   always #5 ACLK = ~ACLK;

   axi4lite_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
   );

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          waits;   // ACCESS cycles the slave holds PREADY low
      logic [31:0] prdata;
      logic        slverr;
   } xfer_t;

   xfer_t exp_q[$];
   xfer_t cur;
   logic  apb_log[$];
   logic  in_xfer = 1'b0;
   int    acc = 0;
   int    psel_edge = 0, pen_edge = 0, vld_edge = 0;
   int    total = 0, passed = 0;
   int    cyc = 0;
   logic  rst_edge = 1'b1;

   always @(posedge ACLK) begin
      cyc      <= cyc + 1;
      rst_edge <= ARESETn;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic xfer_t mk(input logic [31:0] a, input logic wr, input logic [31:0] d,
                                input logic [3:0] s, input int waits, input logic [31:0] prd,
                                input logic err);
      xfer_t x;
      x.addr = a; x.wr = wr; x.data = d; x.strb = wr ? s : 4'h0;
      x.waits = waits; x.prdata = prd; x.slverr = err;
      return x;
   endfunction

   task automatic chk_apb(input string tag);
      chk({tag, "_paddr"}, PADDR, cur.addr);
      chk({tag, "_pwrite"}, PWRITE, cur.wr);
      chk({tag, "_pstrb"}, PSTRB, cur.strb);
      if (cur.wr) chk({tag, "_pwdata"}, PWDATA, cur.data);
   endtask

   // Compare process and APB slave: everything sampled/driven at the falling edge.
   initial begin
      logic pv_psel, pv_pen, pv_vld, terr;
      pv_psel = 1'b0; pv_pen = 1'b0; pv_vld = 1'b0;
      cur = mk(32'h0, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0);
      forever begin
         @(negedge ACLK);
         if (!rst_edge) begin
            chk("rst_ctrl", {PSEL, PENABLE, PWRITE, BVALID, RVALID, BRESP, RRESP, PSTRB}, 64'h0);
            chk("rst_apb_data", {PADDR, PWDATA}, 64'h0);
            chk("rst_rdata", RDATA, 64'h0);
            if (!ARESETn) chk("rst_ready", {AWREADY, WREADY, ARREADY}, 64'h0);
            in_xfer = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
            pv_psel = 1'b0; pv_pen = 1'b0; pv_vld = 1'b0;
         end else begin
            if (PSEL && !PENABLE) begin
               apb_log.push_back(PWRITE);
               if (exp_q.size() == 0) chk("apb_unexpected", exp_q.size(), 1);
               else begin
                  cur = exp_q.pop_front();
                  in_xfer = 1'b1;
                  acc = 0;
                  chk_apb("setup");
               end
            end
            if (PSEL && PENABLE) begin
               chk("access_in_xfer", in_xfer, 1);
               acc++;
               chk_apb("access");
               chk("access_bound", acc <= TMO, 1);
               PREADY  = (acc > cur.waits);
               PRDATA  = cur.prdata;
               PSLVERR = cur.slverr;
            end else begin
               PREADY  = 1'b0;
               PSLVERR = 1'b0;
            end
            if (BVALID || RVALID) begin
               terr = (cur.waits >= TMO);
               chk("resp_in_xfer", in_xfer, 1);
               chk("resp_chan", {BVALID, RVALID}, cur.wr ? 2'b10 : 2'b01);
               chk("resp_no_psel", PSEL, 0);
               if (cur.wr) chk("bresp", BRESP, (cur.slverr || terr) ? 2'b10 : 2'b00);
               else begin
                  chk("rresp", RRESP, (cur.slverr || terr) ? 2'b10 : 2'b00);
                  chk("rdata", RDATA, terr ? 32'h0 : cur.prdata);
               end
            end else if (pv_vld) begin
               in_xfer = 1'b0;
            end
            if (PSEL && !pv_psel) psel_edge = cyc;
            if (PENABLE && !pv_pen) pen_edge = cyc;
            if ((BVALID || RVALID) && !pv_vld) vld_edge = cyc;
            pv_psel = PSEL; pv_pen = PENABLE; pv_vld = BVALID || RVALID;
         end
      end
   end

   task automatic send_aw(input logic [31:0] a, output int e);
      int n = 0;
      @(negedge ACLK);
      AWADDR = a; AWVALID = 1'b1;
      while (!AWREADY && n < 100) begin @(negedge ACLK); n++; end
      chk("aw_wait", n < 100, 1);
      e = cyc + 1;
      @(posedge ACLK); #1 AWVALID = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int e);
      int n = 0;
      @(negedge ACLK);
      WDATA = d; WSTRB = s; WVALID = 1'b1;
      while (!WREADY && n < 100) begin @(negedge ACLK); n++; end
      chk("w_wait", n < 100, 1);
      e = cyc + 1;
      @(posedge ACLK); #1 WVALID = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, output int e);
      int n = 0;
      @(negedge ACLK);
      ARADDR = a; ARVALID = 1'b1;
      while (!ARREADY && n < 100) begin @(negedge ACLK); n++; end
      chk("ar_wait", n < 100, 1);
      e = cyc + 1;
      @(posedge ACLK); #1 ARVALID = 1'b0;
   endtask

   task automatic recv_b(input int hold, output logic [1:0] resp);
      int n = 0;
      @(negedge ACLK);
      while (!BVALID && n < 200) begin @(negedge ACLK); n++; end
      chk("b_wait", n < 200, 1);
      resp = BRESP;
      for (int i = 0; i < hold; i++) begin @(negedge ACLK); chk("b_hold", BVALID, 1); end
      BREADY = 1'b1;
      @(posedge ACLK); #1 BREADY = 1'b0;
   endtask

   task automatic recv_r(input int hold, output logic [1:0] resp, output logic [31:0] d);
      int n = 0;
      @(negedge ACLK);
      while (!RVALID && n < 200) begin @(negedge ACLK); n++; end
      chk("r_wait", n < 200, 1);
      resp = RRESP; d = RDATA;
      for (int i = 0; i < hold; i++) begin @(negedge ACLK); chk("r_hold", RVALID, 1); end
      RREADY = 1'b1;
      @(posedge ACLK); #1 RREADY = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge ACLK); #1 ARESETn = 1'b0;
      repeat (2) @(posedge ACLK);
      #1 ARESETn = 1'b1;
   endtask

   initial begin
      int ea, ew, er, e0, seen, n;
      logic [1:0] rs, rs2;
      logic [31:0] rd;

      repeat (3) @(posedge ACLK);
      #1 ARESETn = 1'b1;
      @(negedge ACLK);
      chk("init_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
      chk("init_idle", {PSEL, PENABLE, BVALID, RVALID}, 4'b0000);

      // Aligned AW+W write, zero wait states: cycle-exact latency
      exp_q.push_back(mk(32'h1000_0000, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0));
      fork
         send_aw(32'h1000_0000, ea);
         send_w(32'hDEADBEEF, 4'hF, ew);
      join
      e0 = (ea > ew) ? ea : ew;
      recv_b(0, rs);
      chk("t1_psel_edge", psel_edge, e0 + 1);
      chk("t1_penable_edge", pen_edge, e0 + 2);
      chk("t1_bvalid_edge", vld_edge, e0 + 3);
      chk("t1_bresp", rs, 2'b00);
      chk("t1_access_cycles", acc, 1);

      // W leads AW by four cycles; APB stays idle until AW lands
      exp_q.push_back(mk(32'h2000_0004, 1'b1, 32'hCAFE0123, 4'h3, 0, 32'h0, 1'b0));
      send_w(32'hCAFE0123, 4'h3, ew);
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         chk("t2_wready_low", WREADY, 0);
         seen += PSEL;
      end
      chk("t2_no_apb_before_aw", seen, 0);
      send_aw(32'h2000_0004, ea);
      recv_b(0, rs);
      chk("t2_psel_edge", psel_edge, ea + 1);
      chk("t2_bresp", rs, 2'b00);

      // Read with three wait states, response held off by RREADY
      exp_q.push_back(mk(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3, 32'h1234_5678, 1'b0));
      send_ar(32'h0000_0040, er);
      recv_r(4, rs, rd);
      chk("t3_penable_cycles", acc, 4);
      chk("t3_rdata", rd, 32'h1234_5678);
      chk("t3_rresp", rs, 2'b00);
      chk("t3_rvalid_edge", vld_edge, er + 6);

      // Simultaneous write and read after reset: write wins, read follows
      do_reset();
      apb_log.delete();
      exp_q.push_back(mk(32'h0000_0100, 1'b1, 32'h0000_00A1, 4'hF, 0, 32'h0, 1'b0));
      exp_q.push_back(mk(32'h0000_0200, 1'b0, 32'h0, 4'h0, 0, 32'hBEEF_0001, 1'b0));
      fork
         send_aw(32'h0000_0100, ea);
         send_w(32'h0000_00A1, 4'hF, ew);
         send_ar(32'h0000_0200, er);
      join
      fork
         recv_b(0, rs);
         recv_r(0, rs2, rd);
      join
      chk("t4_order_count", apb_log.size(), 2);
      if (apb_log.size() == 2) begin
         chk("t4_first_is_write", apb_log[0], 1);
         chk("t4_second_is_read", apb_log[1], 0);
      end
      chk("t4_rdata", rd, 32'hBEEF_0001);

      // A lone write leaves last-grant = write, so the next contest goes to the read
      exp_q.push_back(mk(32'h0000_0300, 1'b1, 32'h0000_00B2, 4'h1, 1, 32'h0, 1'b0));
      fork
         send_aw(32'h0000_0300, ea);
         send_w(32'h0000_00B2, 4'h1, ew);
      join
      recv_b(0, rs);
      apb_log.delete();
      exp_q.push_back(mk(32'h0000_0400, 1'b0, 32'h0, 4'h0, 0, 32'hBEEF_0002, 1'b0));
      exp_q.push_back(mk(32'h0000_0500, 1'b1, 32'h0000_00C3, 4'hF, 0, 32'h0, 1'b0));
      fork
         send_aw(32'h0000_0500, ea);
         send_w(32'h0000_00C3, 4'hF, ew);
         send_ar(32'h0000_0400, er);
      join
      fork
         recv_b(0, rs);
         recv_r(0, rs2, rd);
      join
      chk("t4b_order_count", apb_log.size(), 2);
      if (apb_log.size() == 2) begin
         chk("t4b_first_is_read", apb_log[0], 0);
         chk("t4b_second_is_write", apb_log[1], 1);
      end

      // PREADY stuck low: forced SLVERR after TMO ACCESS cycles
      exp_q.push_back(mk(32'h3000_0000, 1'b1, 32'h0000_0055, 4'hF, 1000, 32'h0, 1'b0));
      fork
         send_aw(32'h3000_0000, ea);
         send_w(32'h0000_0055, 4'hF, ew);
      join
      e0 = (ea > ew) ? ea : ew;
      recv_b(0, rs);
      chk("t5_bresp", rs, 2'b10);
      chk("t5_access_cycles", acc, 16);
      chk("t5_bvalid_edge", vld_edge, e0 + 18);

      exp_q.push_back(mk(32'h3000_0010, 1'b0, 32'h0, 4'h0, 1000, 32'hFFFF_FFFF, 1'b0));
      send_ar(32'h3000_0010, er);
      recv_r(0, rs, rd);
      chk("t5_read_tmo_rresp", rs, 2'b10);
      chk("t5_read_tmo_rdata", rd, 32'h0);

      exp_q.push_back(mk(32'h3000_0020, 1'b0, 32'h0, 4'h0, 1, 32'h0000_ABCD, 1'b1));
      send_ar(32'h3000_0020, er);
      recv_r(2, rs, rd);
      chk("t5_slverr_rresp", rs, 2'b10);
      chk("t5_slverr_rdata", rd, 32'h0000_ABCD);

      // Reset in the middle of ACCESS: transfer dropped, no response ever appears
      exp_q.push_back(mk(32'h5000_0000, 1'b1, 32'h0000_0077, 4'hF, 1000, 32'h0, 1'b0));
      fork
         send_aw(32'h5000_0000, ea);
         send_w(32'h0000_0077, 4'hF, ew);
      join
      n = 0;
      while (!(PENABLE && acc >= 3) && n < 50) begin @(negedge ACLK); n++; end
      chk("t6_reached_access", n < 50, 1);
      @(posedge ACLK); #1 ARESETn = 1'b0;
      @(negedge ACLK);
      chk("t6_readys_low_in_reset", {AWREADY, WREADY, ARREADY}, 3'b000);
      @(negedge ACLK);
      chk("t6_dropped", {PSEL, PENABLE, BVALID}, 3'b000);
      @(posedge ACLK); #1 ARESETn = 1'b1;
      exp_q.delete();
      @(negedge ACLK);
      chk("t6_ready_after_release", {AWREADY, WREADY, ARREADY}, 3'b111);
      seen = 0;
      repeat (20) begin @(negedge ACLK); seen += BVALID + RVALID + PSEL; end
      chk("t6_no_stale", seen, 0);

      // Bridge is usable again after the mid-transfer reset
      exp_q.push_back(mk(32'h6000_0008, 1'b1, 32'h0BAD_F00D, 4'hC, 2, 32'h0, 1'b0));
      fork
         send_aw(32'h6000_0008, ea);
         send_w(32'h0BAD_F00D, 4'hC, ew);
      join
      recv_b(0, rs);
      chk("t7_bresp", rs, 2'b00);
      chk("t7_access_cycles", acc, 3);

      repeat (3) @(negedge ACLK);
      chk("expected_all_done", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
      $fatal(1);
   end

endmodule
